// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the load/store path into the word data memory.
// Holds the RV32I load/store funct3 encodings and the LSU state encoding.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
// Ports:
//   chk_we, chk_funct3, chk_addr : incoming request, checked for faults
//   fault                        : misaligned address or illegal funct3
//   funct3, addr_lo              : latched request used for lane handling
//   ld_word                      : word read from memory
//   ld_data                      : selected lane, sign/zero extended
//   st_word, st_data             : old memory word and store data (low half)
//   st_merged                    : old word with the addressed lane replaced
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic        chk_we,
    input  logic [2:0]  chk_funct3,
    input  logic [1:0]  chk_addr,
    output logic        fault,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data,
    input  logic [31:0] st_word,
    input  logic [15:0] st_data,
    output logic [31:0] st_merged
);

    logic        illegal;
    logic        misaligned;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;

    always_comb begin
        if (chk_we) begin
            illegal = chk_funct3[2] || (chk_funct3 == 3'b011);
        end else begin
            illegal = (chk_funct3 == 3'b011) || (chk_funct3 == 3'b110) ||
                      (chk_funct3 == 3'b111);
        end
        // funct3[1:0] encodes the access size for every legal encoding.
        case (chk_funct3[1:0])
            2'b01:   misaligned = chk_addr[0];
            2'b10:   misaligned = |chk_addr;
            default: misaligned = 1'b0;
        endcase
        fault = illegal || misaligned;
    end

    // Little-endian lanes: byte lane k sits at bits [8k+7:8k].
    always_comb begin
        ld_shift = ld_word >> {addr_lo, 3'b000};
        ld_half  = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (funct3)
            F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_merged = st_word;
        case (funct3[1:0])
            2'b00:   st_merged[{addr_lo, 3'b000} +: 8]      = st_data[7:0];
            2'b01:   st_merged[{addr_lo[1], 4'b0000} +: 16] = st_data;
            default: st_merged = st_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32I loads/stores into accesses on a
// single-port word memory (async read, sync write). Sub-word stores are done
// as read-modify-write. Misaligned or illegal requests answer with a fault.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready                 : request handshake (accept in IDLE)
//   req_we, req_funct3, req_addr, req_wdata : request payload
//   rsp_valid/rsp_ready                 : response handshake
//   rsp_rdata, rsp_fault                : response payload
//   mem_A, mem_WE, mem_WD, mem_RD       : data memory port
//   dbg_state                           : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the sender keeps valid and payload stable until that edge.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_fault,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [WIDTH-1:0]  mem_WD,
    input  logic [WIDTH-1:0]  mem_RD,
    output lsu_state_t        dbg_state
);

    lsu_state_t         state;
    logic               we_q;
    logic [2:0]         f3_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH-1:0]   word_q;

    logic               chk_fault;
    logic [WIDTH-1:0]   ld_data;
    logic [WIDTH-1:0]   st_merged;

    // Address bits above the memory size are dropped (accesses wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[WIDTH-1:ADDR_W+2];

    lsu_align u_align (
        .chk_we     (req_we),
        .chk_funct3 (req_funct3),
        .chk_addr   (req_addr[1:0]),
        .fault      (chk_fault),
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .ld_word    (mem_RD),
        .ld_data    (ld_data),
        .st_word    (word_q),
        .st_data    (wdata_q[15:0]),
        .st_merged  (st_merged)
    );

    // Memory controls decode straight from the state register so that the
    // asynchronous reset removes mem_WE at once and no partial write lands.
    assign req_ready = (state == ST_IDLE);
    assign mem_WE    = (state == ST_WRITE);
    assign mem_A     = (state == ST_READ || state == ST_WRITE) ? addr_q[ADDR_W+1:2] : '0;
    assign mem_WD    = (state != ST_WRITE) ? '0 :
                       (f3_q == F3_W)      ? wdata_q : st_merged;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            word_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        if (chk_fault) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (!req_we || req_funct3 != F3_W) begin
                            // Loads, and sub-word stores needing the old word.
                            state <= ST_READ;
                        end else begin
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    word_q <= mem_RD;
                    if (!we_q) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ld_data;
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import riscv_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [5:0]  mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;
    lsu_state_t  dbg_state;

    load_store_unit #(.WIDTH(32), .ADDR_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD),
        .mem_RD(mem_RD), .dbg_state(dbg_state)
    );

    // ---------------- data memory (plus preload port) ----------------
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;
    assign mem_RD = mem[mem_A];
    always @(posedge clk) begin
        if (mem_WE) mem[mem_A] <= mem_WD;
        else if (pl_en) mem[pl_idx] <= pl_val;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] ref_mem [64];
    logic [31:0] exp_q[$];         // expected rdata of each accepted request
    int          cyc = 0;
    int          n_acc = 0;
    logic        m_busy = 1'b0;
    int          m_acc = 0;
    int          m_lat = 0;
    logic        m_wr = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_new = 32'h0;
    logic [5:0]  m_idx = 6'd0;

    function automatic void model_op(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     input logic [31:0] old, output logic flt,
                                     output logic [31:0] rd, output logic [31:0] nw,
                                     output int lat, output logic wr);
        int size, off;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr % 4);
        if (we) flt = (f3 >= 3'd4) || (f3 == 3'd3);
        else    flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (!flt && (off % size) != 0) flt = 1'b1;
        rd = 32'h0; nw = old; wr = 1'b0; lat = 1;
        if (flt) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            v = old >> (8 * off);
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            rd = v;
        end else begin
            wr  = 1'b1;
            lat = (size == 4) ? 2 : 3;
            for (int i = 0; i < size; i++) nw[8*(off+i) +: 8] = wd[8*i +: 8];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int rel;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else begin
            rel = cyc - m_acc + 1;
            if (pl_en) ref_mem[pl_idx] = pl_val;
            if (m_busy) begin
                if (m_wr && rel == m_lat - 1) ref_mem[m_idx] = m_new;
                if (rel >= m_lat && rsp_ready) m_busy = 1'b0;
            end else if (req_valid) begin
                m_idx = req_addr[7:2];
                model_op(req_we, req_funct3, req_addr, req_wdata, ref_mem[req_addr[7:2]],
                         m_fault, m_rdata, m_new, m_lat, m_wr);
                exp_q.push_back(m_rdata);
                m_busy = 1'b1;
                m_acc  = cyc + 1;
                n_acc++;
            end
            cyc++;
        end
    end

    // ---------------- compare process ----------------
    logic [31:0] got_rdata = 32'h0;
    logic        got_fault = 1'b0;
    always @(negedge clk) begin
        int  rel;
        logic rsp_on, wr_on;
        if (rst_n) begin
            rel    = cyc - m_acc + 1;
            rsp_on = m_busy && rel >= m_lat;
            wr_on  = m_busy && m_wr && rel == m_lat - 1;
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("rsp_valid", 32'(rsp_valid), 32'(rsp_on));
            chk("mem_WE", 32'(mem_WE), 32'(wr_on));
            if (rsp_on) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
                got_rdata = rsp_rdata;
                got_fault = rsp_fault;
            end
            if (wr_on) begin
                chk("mem_A", 32'(mem_A), 32'(m_idx));
                chk("mem_WD", mem_WD, m_new);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pl_idx = idx; pl_val = val; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall);
        int n0;
        bit ok;
        n0 = n_acc;
        rsp_ready  = (stall == 0);
        req_we     = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        req_valid  = 1'b1;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (n_acc != n0) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd1, 32'd0);
        req_valid = 1'b0;
        if (stall > 0) begin
            // A second request shown while busy must be ignored.
            req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'h12345678;
            req_valid = 1'b1;
            repeat (stall + 1) begin @(posedge clk); #1; end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (!m_busy) begin ok = 1; break; end
        end
        if (!ok) chk("rsp_timeout", 32'd1, 32'd0);
        rsp_ready = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_WE", 32'(mem_WE), 32'd0);
        chk("rst_mem_A", 32'(mem_A), 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        preload(6'd2, 32'h0);
        do_op(1'b1, F3_W, 32'h08, 32'hDEADBEEF, 0);
        chk("sw_mem2", mem[2], 32'hDEADBEEF);
        chk("sw_rdata", got_rdata, 32'h0);

        preload(6'd2, 32'h11223344);
        do_op(1'b1, F3_B, 32'h09, 32'h000000AA, 0);
        chk("sb_mem2", mem[2], 32'h1122AA44);
        chk("sb_model", ref_mem[2], 32'h1122AA44);

        preload(6'd2, 32'h80FF0000);
        do_op(1'b0, F3_B, 32'h0B, 32'h0, 0);
        chk("lb_model", m_rdata, 32'hFFFFFF80);
        chk("lb_dut", got_rdata, 32'hFFFFFF80);
        do_op(1'b0, F3_BU, 32'h0B, 32'h0, 0);
        chk("lbu_dut", got_rdata, 32'h00000080);
        do_op(1'b0, F3_H, 32'h0A, 32'h0, 0);
        chk("lh_model", m_rdata, 32'hFFFF80FF);
        chk("lh_dut", got_rdata, 32'hFFFF80FF);
        do_op(1'b0, F3_HU, 32'h0A, 32'h0, 0);
        chk("lhu_dut", got_rdata, 32'h000080FF);
        do_op(1'b0, F3_W, 32'h08, 32'h0, 0);
        chk("lw_dut", got_rdata, 32'h80FF0000);

        do_op(1'b0, F3_H, 32'h03, 32'h0, 0);
        chk("lh_mis_fault", 32'(got_fault), 32'd1);
        do_op(1'b1, F3_W, 32'h06, 32'hFFFFFFFF, 0);
        chk("sw_mis_fault", 32'(got_fault), 32'd1);
        chk("sw_mis_mem", mem[1], 32'(mem[1]) === 32'hFFFFFFFF ? 32'h0 : mem[1]);
        do_op(1'b0, 3'b011, 32'h08, 32'h0, 0);
        chk("ld_f3_011_fault", 32'(got_fault), 32'd1);
        do_op(1'b1, F3_BU, 32'h08, 32'h0, 0);
        chk("st_f3_100_fault", 32'(got_fault), 32'd1);

        do_op(1'b1, F3_H, 32'h0A, 32'h00005555, 0);
        chk("sh_mem2", mem[2], 32'h55550000);
        do_op(1'b0, F3_W, 32'h108, 32'h0, 0);
        chk("lw_wrap", got_rdata, 32'h55550000);
        do_op(1'b0, F3_W, 32'h08, 32'h0, 5);
        chk("lw_stall", got_rdata, 32'h55550000);
        chk("stall_no_write", mem[0] === 32'h12345678 ? 32'd1 : 32'd0, 32'd0);

        // Reset during the WRITE cycle of an SH.
        preload(6'd5, 32'hCAFEF00D);
        req_we = 1'b1; req_funct3 = F3_H; req_addr = 32'h16; req_wdata = 32'h00001234;
        req_valid = 1'b1;
        begin
            int n0;
            bit ok;
            n0 = n_acc; ok = 0;
            for (int t = 0; t < 20; t++) begin
                @(posedge clk); #1;
                if (n_acc != n0) begin ok = 1; break; end
            end
            if (!ok) chk("rst_accept_timeout", 32'd1, 32'd0);
        end
        req_valid = 1'b0;
        @(posedge clk); #2;
        chk("sh_we_before_rst", 32'(mem_WE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_we_drop", 32'(mem_WE), 32'd0);
        chk("rst_mem_A_drop", 32'(mem_A), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem5", mem[5], 32'hCAFEF00D);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid_late", 32'(rsp_valid), 32'd0);
        chk("accepted_count", 32'(exp_q.size()), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
